// File: rtl/chunk_unloader_if.sv
// Handshake bundle between the line buffer / host and the chunk unloader.
// The slave side is the unloader; the master side is the line source plus the host.
interface chunk_unloader_if #(
  parameter int num_bits = 512
);
  logic                flush;
  logic [num_bits-1:0] chunk_in;
  logic                chunk_valid;
  logic                chunk_ready;
  logic [7:0]          byte_out;
  logic [8:0]          byte_offset;
  logic                byte_valid;
  logic                byte_ready;
  logic                byte_last;
  logic                busy;

  modport master (
    output flush, chunk_in, chunk_valid, byte_ready,
    input  chunk_ready, byte_out, byte_offset, byte_valid, byte_last, busy
  );

  modport slave (
    input  flush, chunk_in, chunk_valid, byte_ready,
    output chunk_ready, byte_out, byte_offset, byte_valid, byte_last, busy
  );
endinterface

// File: rtl/chunk_unloader.sv
// Drains one captured line to the host one byte per handshake, lowest byte first,
// tagging each byte with its MSB bit offset within the line (8k+7).
module chunk_unloader #(
  parameter int num_bits = 512
) (
  input logic             clk,
  input logic             rst_n,
  chunk_unloader_if.slave bus
);
  localparam int NB = num_bits / 8;
  localparam int IW = $clog2(NB);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [num_bits-1:0] shreg_q, shreg_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic                last;
  logic                accept;

  assign last   = (cnt_q == IW'(NB - 1));
  assign accept = (state_q == SEND) && bus.byte_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.chunk_valid) begin
            shreg_d = bus.chunk_in;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (accept) begin
            shreg_d = {8'h00, shreg_q[num_bits-1:8]};
            // Counter parks on the last index rather than wrapping.
            if (last) state_d = IDLE;
            else      cnt_d   = cnt_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from registered state; byte_last is gated since cnt parks at NB-1.
  assign bus.chunk_ready = (state_q == IDLE);
  assign bus.byte_valid  = (state_q == SEND);
  assign bus.busy        = (state_q == SEND);
  assign bus.byte_out    = shreg_q[7:0];
  assign bus.byte_offset = 9'({cnt_q, 3'b111});
  assign bus.byte_last   = (state_q == SEND) && last;
endmodule

// File: tb/tb_chunk_unloader.sv
// Directed and randomized bench for chunk_unloader, with a byte-queue scoreboard
// derived from the line contents and a separate 16-bit instance.
module tb_chunk_unloader;
  localparam int NBITS = 512;
  localparam int NB    = NBITS / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chunk_unloader_if #(.num_bits(NBITS)) u ();
  chunk_unloader_if #(.num_bits(16))    u16 ();

  chunk_unloader #(.num_bits(NBITS)) dut (.clk(clk), .rst_n(rst_n), .bus(u));
  chunk_unloader #(.num_bits(16))    dut16 (.clk(clk), .rst_n(rst_n), .bus(u16));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input bit full_reset);
    chk({tag, "_cready"}, 64'(u.chunk_ready), 64'd1);
    chk({tag, "_bvalid"}, 64'(u.byte_valid), 64'd0);
    chk({tag, "_busy"}, 64'(u.busy), 64'd0);
    chk({tag, "_last"}, 64'(u.byte_last), 64'd0);
    if (full_reset) begin
      chk({tag, "_byte"}, 64'(u.byte_out), 64'd0);
      chk({tag, "_offset"}, 64'(u.byte_offset), 64'd7);
    end
  endtask

  // mode: 0 = byte_ready always 1, 1 = pattern 1,0,0,1, 2 = random.
  // hold: keep chunk_valid high with a different chunk_in during SEND.
  // abort_after >= 0: after that many accepted bytes apply flush (kind 0) or reset (kind 1).
  task automatic drain(input logic [NBITS-1:0] line, input int mode, input bit hold,
                       input int abort_after, input int abort_kind);
    logic [7:0] q[$];
    int acc    = 0;
    int stalls = 0;
    int cyc    = 0;
    bit rdy;
    for (int k = 0; k < NB; k++) q.push_back(line[8*k +: 8]);
    chk("pre_cready", 64'(u.chunk_ready), 64'd1);
    u.chunk_in    = line;
    u.chunk_valid = 1'b1;
    u.byte_ready  = 1'b0;
    tick();
    if (hold) u.chunk_in = ~line;
    else      u.chunk_valid = 1'b0;
    while (q.size() > 0 && cyc < 4 * NB + 8) begin
      if (abort_after >= 0 && acc == abort_after) break;
      chk("bvalid", 64'(u.byte_valid), 64'd1);
      chk("cready_send", 64'(u.chunk_ready), 64'd0);
      chk("busy_send", 64'(u.busy), 64'd1);
      chk("byte", 64'(u.byte_out), 64'(q[0]));
      chk("offset", 64'(u.byte_offset), 64'(8 * acc + 7));
      chk("last", 64'(u.byte_last), 64'(q.size() == 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      u.byte_ready = rdy;
      tick();
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        acc++;
      end else begin
        stalls++;
      end
    end
    if (abort_after >= 0) begin
      chk("abort_point", 64'(acc), 64'(abort_after));
      if (abort_kind == 0) begin
        u.flush      = 1'b1;
        u.byte_ready = 1'b0;
        tick();
        u.flush = 1'b0;
        chk_idle("flush", 1'b0);
      end else begin
        rst_n        = 1'b0;
        u.byte_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk_idle("midreset", 1'b1);
      end
      u.chunk_valid = 1'b0;
      u.byte_ready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("no_more_bytes", 64'(u.byte_valid), 64'd0);
      end
    end else begin
      chk("timeout", 64'(q.size()), 64'd0);
      chk("latency", 64'(cyc), 64'(NB + stalls));
      chk_idle("done", 1'b0);
    end
    u.byte_ready = 1'b0;
  endtask

  function automatic logic [NBITS-1:0] rand_line();
    logic [NBITS-1:0] l;
    for (int i = 0; i < NBITS / 32; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  logic [NBITS-1:0] ramp, la5, l5a;

  initial begin
    rst_n         = 1'b0;
    u.flush       = 1'b0;
    u.chunk_in    = '0;
    u.chunk_valid = 1'b0;
    u.byte_ready  = 1'b0;
    u16.flush       = 1'b0;
    u16.chunk_in    = '0;
    u16.chunk_valid = 1'b0;
    u16.byte_ready  = 1'b0;
    tick();
    chk_idle("reset", 1'b1);
    chk("r16_cready", 64'(u16.chunk_ready), 64'd1);
    chk("r16_offset", 64'(u16.byte_offset), 64'd7);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset", 1'b1);

    for (int k = 0; k < NB; k++) ramp[8*k +: 8] = 8'(k);
    drain(ramp, 0, 1'b0, -1, 0);
    drain(ramp, 1, 1'b0, -1, 0);

    for (int k = 0; k < NB; k++) begin
      la5[8*k +: 8] = 8'hA5;
      l5a[8*k +: 8] = 8'h5A;
    end
    drain(la5, 0, 1'b1, -1, 0);
    drain(l5a, 0, 1'b0, -1, 0);

    drain(rand_line(), 2, 1'b0, 11, 0);
    drain(rand_line(), 2, 1'b0, -1, 0);

    drain(rand_line(), 0, 1'b0, 21, 1);

    // flush and chunk_valid together in IDLE: no capture
    u.chunk_in    = rand_line();
    u.chunk_valid = 1'b1;
    u.flush       = 1'b1;
    tick();
    u.flush       = 1'b0;
    u.chunk_valid = 1'b0;
    chk_idle("flush_idle", 1'b0);
    tick();
    chk_idle("flush_idle2", 1'b0);

    for (int n = 0; n < 4; n++) drain(rand_line(), 2, 1'(n % 2), -1, 0);
    u.chunk_valid = 1'b0;
    tick();

    // 16-bit instance
    u16.chunk_in    = 16'hBEEF;
    u16.chunk_valid = 1'b1;
    u16.byte_ready  = 1'b1;
    tick();
    u16.chunk_valid = 1'b0;
    chk("n16_v0", 64'(u16.byte_valid), 64'd1);
    chk("n16_b0", 64'(u16.byte_out), 64'hEF);
    chk("n16_o0", 64'(u16.byte_offset), 64'd7);
    chk("n16_l0", 64'(u16.byte_last), 64'd0);
    tick();
    chk("n16_v1", 64'(u16.byte_valid), 64'd1);
    chk("n16_b1", 64'(u16.byte_out), 64'hBE);
    chk("n16_o1", 64'(u16.byte_offset), 64'd15);
    chk("n16_l1", 64'(u16.byte_last), 64'd1);
    tick();
    chk("n16_done_v", 64'(u16.byte_valid), 64'd0);
    chk("n16_done_r", 64'(u16.chunk_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
